// File: rtl/mem_pkg.sv
// Shared types and constants for the fetch/load-store RAM arbiter.
// Holds the data width, the d_access encodings and the arbiter state enum.
package mem_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [2:0] ACC_SB = 3'b000;
  localparam logic [2:0] ACC_SH = 3'b001;
  localparam logic [2:0] ACC_W  = 3'b010;
  localparam logic [2:0] ACC_UB = 3'b100;
  localparam logic [2:0] ACC_UH = 3'b101;

  typedef enum logic {IDLE, RMW} state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit little-endian word: load extract/extend
// and sub-word store merge, shared by the load return and RMW write paths.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  logic [2:0]            access,
  input  logic [15:0]           wdata_lo,
  output logic [WORD_WIDTH-1:0] load_data,
  output logic [WORD_WIDTH-1:0] merged
);

  logic        is_byte;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign is_byte  = ~access[0];
  assign byte_val = 8'(rdata >> {offset, 3'b000});
  assign half_val = 16'(rdata >> {offset[1], 4'b0000});

  always_comb begin
    load_data = rdata;
    case (access)
      ACC_SB:  load_data = {{(WORD_WIDTH-8){byte_val[7]}}, byte_val};
      ACC_UB:  load_data = {{(WORD_WIDTH-8){1'b0}}, byte_val};
      ACC_SH:  load_data = {{(WORD_WIDTH-16){half_val[15]}}, half_val};
      ACC_UH:  load_data = {{(WORD_WIDTH-16){1'b0}}, half_val};
      default: load_data = rdata;
    endcase
  end

  // Each lane either keeps the old RAM byte or takes the matching store byte.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       sel;
    logic [7:0] src;
    assign sel = is_byte ? (offset == LANE) : (offset[1] == LANE[1]);
    assign src = (is_byte || !LANE[0]) ? wdata_lo[7:0] : wdata_lo[15:8];
    assign merged[gi*8 +: 8] = sel ? src : rdata[gi*8 +: 8];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for instruction fetch and load/store, with load
// alignment and RMW sub-word stores. Define MEM_ARB_PERF_EN for perf_conflicts.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [WORD_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [WORD_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WORD_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  input  logic [2:0]            d_access,
  output logic                  d_gnt,
  output logic                  d_err,
  output logic                  d_rvalid,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_conflicts
`endif
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t                state_reg, state_next;
  logic [3:0]            starve_cnt_reg;
  logic                  i_rvalid_reg, d_rvalid_reg;
  logic [WORD_WIDTH-1:0] i_hold_reg, d_hold_reg;
  logic [1:0]            lane_off_reg;
  logic [2:0]            lane_acc_reg;
  logic                  d_legal, starved, lane_capture, d_load_gnt;
  logic [WORD_WIDTH-1:0] load_data, merged_word;
  logic [ADDR_WIDTH-3:0] i_word, d_word;
  logic                  unused_addr_bits;

  assign i_word  = i_addr[ADDR_WIDTH-1:2];
  assign d_word  = d_addr[ADDR_WIDTH-1:2];
  assign starved = i_req && (starve_cnt_reg == STARVE_MAX);
  assign unused_addr_bits = ^{i_addr[WORD_WIDTH-1:ADDR_WIDTH], i_addr[1:0],
                              d_addr[WORD_WIDTH-1:ADDR_WIDTH]};

  always_comb begin
    case (d_access)
      ACC_SB, ACC_UB: d_legal = 1'b1;
      ACC_SH, ACC_UH: d_legal = ~d_addr[0];
      ACC_W:          d_legal = (d_addr[1:0] == 2'b00);
      default:        d_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    d_err        = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    lane_capture = 1'b0;
    d_load_gnt   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_req && !starved) begin
          if (!d_legal) begin
            d_gnt = 1'b1;
            d_err = 1'b1;
          end else begin
            mem_en   = 1'b1;
            mem_addr = d_word;
            if (!d_we) begin
              d_gnt        = 1'b1;
              d_load_gnt   = 1'b1;
              lane_capture = 1'b1;
            end else if (d_access == ACC_W) begin
              mem_we    = 1'b1;
              mem_wdata = d_wdata;
              d_gnt     = 1'b1;
            end else begin
              // Sub-word store: read the target word now, merge next cycle.
              lane_capture = 1'b1;
              state_next   = RMW;
            end
          end
        end else if (i_req) begin
          i_gnt    = 1'b1;
          mem_en   = 1'b1;
          mem_addr = i_word;
        end
      end
      RMW: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = d_word;
        mem_wdata  = merged_word;
        d_gnt      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mem_lane_align u_align (
    .rdata     (mem_rdata),
    .offset    (lane_off_reg),
    .access    (lane_acc_reg),
    .wdata_lo  (d_wdata[15:0]),
    .load_data (load_data),
    .merged    (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      i_rvalid_reg   <= 1'b0;
      d_rvalid_reg   <= 1'b0;
      i_hold_reg     <= '0;
      d_hold_reg     <= '0;
      lane_off_reg   <= '0;
      lane_acc_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      i_rvalid_reg <= i_gnt;
      d_rvalid_reg <= d_load_gnt;
      if (!i_req || i_gnt)
        starve_cnt_reg <= '0;
      else if (starve_cnt_reg != STARVE_MAX)
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      if (lane_capture) begin
        lane_off_reg <= d_addr[1:0];
        lane_acc_reg <= d_access;
      end
      if (i_rvalid_reg) i_hold_reg <= mem_rdata;
      if (d_rvalid_reg) d_hold_reg <= load_data;
    end
  end

  // Read data comes straight off the RAM in the valid cycle, then is held.
  assign i_rvalid = i_rvalid_reg;
  assign d_rvalid = d_rvalid_reg;
  assign i_rdata  = i_rvalid_reg ? mem_rdata : i_hold_reg;
  assign d_rdata  = d_rvalid_reg ? load_data : d_hold_reg;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      perf_reg <= '0;
    else if (i_req && d_req && (perf_reg != 32'hFFFF_FFFF))
      perf_reg <= perf_reg + 32'd1;
  end
  assign perf_conflicts = perf_reg;
`endif

  a_rmw_hold: assert property (@(posedge clk) disable iff (!rst_n)
                               (state_reg == RMW) |-> d_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model, a per-cycle reference model of the
// arbitration/alignment rules, and directed vectors with literal expectations.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_err, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_access;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(6), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_access(d_access),
    .d_gnt(d_gnt), .d_err(d_err), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] ram     [16];
  logic [31:0] ref_mem [16];
  bit          ram_loaded = 1'b0;
  bit          ref_ready  = 1'b0;
  int          n_checks   = 0;
  int          n_fail     = 0;

  function automatic logic [31:0] init_word(int i);
    case (i)
      1:       return 32'h8011_2233;
      2:       return 32'hDEAD_BEEF;
      default: return 32'(i) * 32'h0101_0101;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference rules, written in terms of access size and byte offset.
  function automatic int m_size(logic [2:0] acc);
    case (acc)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_legal(logic [2:0] acc, logic [31:0] a);
    int size = m_size(acc);
    if (size == 0) return 1'b0;
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a, logic [2:0] acc);
    int size = m_size(acc);
    int sh   = 8 * int'(a % 4);
    logic [31:0] mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    logic [31:0] v    = (w >> sh) & mask;
    if (!acc[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_merge(logic [31:0] w, logic [31:0] a, logic [2:0] acc,
                                          logic [31:0] wd);
    int sh = 8 * int'(a % 4);
    logic [31:0] mask = ((32'd1 << (8 * m_size(acc))) - 32'd1) << sh;
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  bit          m_rmw = 0, m_ipend = 0, m_dpend = 0;
  int          m_cnt = 0;
  logic [31:0] m_iexp = '0, m_dexp = '0, m_ihold = '0, m_dhold = '0;

  always @(negedge clk) begin
    logic        e_ig, e_dg, e_err, e_en, e_we;
    logic [3:0]  e_addr;
    logic [31:0] e_wd;
    if (!ref_ready) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
      ref_ready = 1'b1;
    end
    if (!rst_n) begin
      m_rmw = 0; m_ipend = 0; m_dpend = 0; m_cnt = 0; m_ihold = '0; m_dhold = '0;
      check("rst_ctrl", 32'({i_gnt, i_rvalid, d_gnt, d_err, d_rvalid, mem_en, mem_we}), 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      check("rst_d_rdata", d_rdata, 32'd0);
    end else begin
      check("m_i_rvalid", 32'(i_rvalid), 32'(m_ipend));
      check("m_i_rdata", i_rdata, m_ipend ? m_iexp : m_ihold);
      if (m_ipend) m_ihold = m_iexp;
      check("m_d_rvalid", 32'(d_rvalid), 32'(m_dpend));
      check("m_d_rdata", d_rdata, m_dpend ? m_dexp : m_dhold);
      if (m_dpend) m_dhold = m_dexp;
      e_ig = 0; e_dg = 0; e_err = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
      if (m_rmw) begin
        e_en = 1; e_we = 1; e_dg = 1; e_addr = d_addr[5:2];
        e_wd = m_merge(ref_mem[e_addr], d_addr, d_access, d_wdata);
        ref_mem[e_addr] = e_wd;
        m_rmw = 0;
      end else if (i_req && (m_cnt == LIMIT || !d_req)) begin
        e_ig = 1; e_en = 1; e_addr = i_addr[5:2];
        m_iexp = ref_mem[e_addr];
      end else if (d_req) begin
        if (!m_legal(d_access, d_addr)) begin
          e_dg = 1; e_err = 1;
        end else begin
          e_en = 1; e_addr = d_addr[5:2];
          if (!d_we) begin
            e_dg = 1;
            m_dexp = m_load(ref_mem[e_addr], d_addr, d_access);
          end else if (m_size(d_access) == 4) begin
            e_dg = 1; e_we = 1; e_wd = d_wdata;
            ref_mem[e_addr] = d_wdata;
          end else begin
            m_rmw = 1;
          end
        end
      end
      m_ipend = e_ig;
      m_dpend = e_dg && !e_err && !d_we;
      if (!i_req || e_ig) m_cnt = 0;
      else if (m_cnt < LIMIT) m_cnt++;
      check("m_i_gnt", 32'(i_gnt), 32'(e_ig));
      check("m_d_gnt", 32'(d_gnt), 32'(e_dg));
      check("m_d_err", 32'(d_err), 32'(e_err));
      check("m_mem_en", 32'(mem_en), 32'(e_en));
      check("m_mem_we", 32'(mem_we), 32'(e_we));
      if (e_en) check("m_mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_we) check("m_mem_wdata", mem_wdata, e_wd);
    end
  end

  task automatic data_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] acc, output logic [31:0] rd, output logic err,
                         output logic en_at_gnt);
    bit got = 1'b0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_access = acc;
    rd = '0; err = 1'b0; en_at_gnt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d_gnt) begin
        got = 1'b1; err = d_err; en_at_gnt = mem_en;
        break;
      end
      @(posedge clk); #1;
    end
    check("d_gnt_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    if (got && !we && !err) begin
      @(negedge clk);
      check("ld_rvalid", 32'(d_rvalid), 32'd1);
      rd = d_rdata;
      @(posedge clk); #1;
    end
    $display("data we=%0b addr=%08h acc=%03b wdata=%08h err=%0b rdata=%08h",
             we, addr, acc, wdata, err, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        err, en;
    logic [9:0]  pat;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_access = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 ram_loaded = 1'b1;
    @(negedge clk);
    check("reset_mem_en", 32'(mem_en), 32'd0);
    check("reset_d_rdata", d_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    check("fetch_gnt", 32'(i_gnt), 32'd1);
    check("fetch_mem_addr", 32'(mem_addr), 32'd2);
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk);
    check("fetch_rvalid", 32'(i_rvalid), 32'd1);
    check("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
    $display("fetch addr=%08h rdata=%08h", i_addr, i_rdata);
    @(posedge clk); #1;
    @(negedge clk);
    check("fetch_hold", i_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    data_op(1'b0, 32'h7, '0, ACC_SB, rd, err, en);  check("lb_7", rd, 32'hFFFF_FF80);
    data_op(1'b0, 32'h7, '0, ACC_UB, rd, err, en);  check("lbu_7", rd, 32'h0000_0080);
    data_op(1'b1, 32'h4, 32'h1122_3344, ACC_W, rd, err, en);
    check("sw_4_err", 32'(err), 32'd0);
    check("sw_4_en", 32'(en), 32'd1);

    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h6; d_wdata = 32'h0000_ABCD; d_access = ACC_SH;
    @(negedge clk);
    check("rmw_rd_en", 32'({mem_en, mem_we, d_gnt}), 32'b100);
    check("rmw_rd_addr", 32'(mem_addr), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rmw_wr_ctl", 32'({mem_en, mem_we, d_gnt, i_gnt}), 32'b1110);
    check("rmw_wr_data", mem_wdata, 32'hABCD_3344);
    @(posedge clk); #1 d_req = 1'b0;
    $display("data we=1 addr=00000006 acc=001 wdata=0000abcd rmw");

    data_op(1'b0, 32'h4, '0, ACC_W, rd, err, en);   check("lw_4", rd, 32'hABCD_3344);
    data_op(1'b1, 32'h5, 32'hFFFF_FF5A, ACC_SB, rd, err, en);
    check("sb_5_err", 32'(err), 32'd0);
    data_op(1'b0, 32'h5, '0, ACC_SB, rd, err, en);  check("lb_5", rd, 32'h0000_005A);
    data_op(1'b0, 32'h6, '0, ACC_SH, rd, err, en);  check("lh_6", rd, 32'hFFFF_ABCD);
    data_op(1'b0, 32'h6, '0, ACC_UH, rd, err, en);  check("lhu_6", rd, 32'h0000_ABCD);

    data_op(1'b1, 32'h2, 32'hCAFE_F00D, ACC_W, rd, err, en);
    check("sw_2_err", 32'(err), 32'd1);
    check("sw_2_en", 32'(en), 32'd0);
    data_op(1'b0, 32'h3, '0, ACC_SH, rd, err, en);  check("lh_3_err", 32'(err), 32'd1);
    data_op(1'b0, 32'h0, '0, 3'b011, rd, err, en);  check("ill_err", 32'(err), 32'd1);
    check("ram0_kept", ram[0], 32'h0);

    pat = 10'b10_0001_0000;
    i_req = 1'b1; i_addr = 32'hC;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_access = ACC_W;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("starve_i_gnt", 32'(i_gnt), 32'(pat[k]));
      check("starve_d_gnt", 32'(d_gnt), 32'(!pat[k]));
      $display("arb cycle=%0d i_gnt=%0b d_gnt=%0b", k, i_gnt, d_gnt);
      @(posedge clk); #1;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h77; d_access = ACC_SB;
    @(negedge clk);
    check("abort_rd", 32'({mem_en, mem_we, d_gnt}), 32'b100);
    @(posedge clk); #1;
    rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("abort_ctl", 32'({mem_en, mem_we, d_gnt}), 32'b000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_ram4", ram[4], 32'h0404_0404);
    $display("reset during rmw addr=00000010 ram4=%08h", ram[4]);

    check("final_ram1", ram[1], 32'hABCD_5A44);
    for (int i = 0; i < 16; i++) check("ram_vs_ref", ram[i], ref_mem[i]);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, word-wide synchronous RAM between the instruction-fetch port and the load/store port of the core.
- One RAM access per cycle; RAM read data is valid one cycle after the access is issued.
- Performs byte-lane alignment, sign/zero extension of loads, and read-modify-write (RMW) for sub-word stores, because the RAM has no byte enables.
- Sits between the core (fetch and LSU) and the RAM macro.

Parameters:
- WORD_WIDTH, 32, data and address width.
- ADDR_WIDTH, 6, byte-address bits decoded by the RAM; RAM word index is addr[ADDR_WIDTH-1:2].
- STARVE_LIMIT, 4, number of consecutive cycles fetch may be denied while requesting before it wins arbitration (range 1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  WORD_WIDTH  fetch byte address; bits [1:0] are ignored.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  i_rdata valid; exactly one cycle after i_gnt.
- i_rdata  out  WORD_WIDTH  fetched word.
- d_req  in  1  data request; held stable with all d_* inputs until d_gnt.
- d_we  in  1  1 = store.
- d_addr  in  WORD_WIDTH  data byte address.
- d_wdata  in  WORD_WIDTH  store data, right-aligned.
- d_access  in  3  000 signed byte, 001 signed half, 010 word, 100 unsigned byte, 101 unsigned half; other codes illegal.
- d_gnt  out  1  data request accepted or completed.
- d_err  out  1  pulses with d_gnt on a misaligned or illegal request.
- d_rvalid  out  1  load data valid; exactly one cycle after d_gnt of a legal load.
- d_rdata  out  WORD_WIDTH  extended load data.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  RAM write this cycle.
- mem_addr  out  ADDR_WIDTH-2  RAM word index.
- mem_wdata  out  WORD_WIDTH  RAM write word.
- mem_rdata  in  WORD_WIDTH  RAM read word, for the access issued in the previous cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; starvation counter 0.
- Reset asserted mid-RMW aborts the RMW: no RAM write occurs and no grant is issued.
- States:
  - IDLE: arbitrate and issue one access this cycle.
  - RMW: the merge/write cycle of a sub-word store.
- Arbitration in IDLE:
  - Data has priority over fetch.
  - Fetch wins when i_req=1 and the starvation counter equals STARVE_LIMIT.
  - The counter increments each cycle i_req=1 without i_gnt, including cycles spent in RMW. It clears on i_gnt or when i_req=0, and saturates at STARVE_LIMIT.
- Legality:
  - Half access with addr[0]=1, word access with addr[1:0]!=0, or an illegal d_access code: d_gnt=1 and d_err=1 in the same cycle, no RAM access, no d_rvalid.
- Fetch or load: mem_en=1, mem_we=0, grant in the issue cycle, rvalid the next cycle.
  - Byte offset and d_access are registered at issue.
  - The next cycle's d_rdata is extracted from mem_rdata by that offset, little-endian: byte lane = addr[1:0], half lane = addr[1].
  - d_rdata is sign-extended for 000/001 and zero-extended for 100/101.
- Word store: mem_en=1, mem_we=1, mem_wdata=d_wdata; d_gnt in the same cycle.
- Sub-word store:
  - IDLE issues a read of the target word (no grant) and moves to RMW.
  - In RMW: mem_we=1 with mem_rdata merged with the low bits of d_wdata in the selected lane; d_gnt=1; return to IDLE.
  - Fetch is blocked both cycles.
- rvalid/rdata outputs are registered-path valid pulses: one cycle wide, data held until the next rvalid.
- Fetch and a load may complete back-to-back. Each rvalid follows its own grant, so i_rvalid and d_rvalid are never high in the same cycle.
- Requests that drop before their grant are ignored. Dropping d_req during RMW is illegal (assertion).

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: adds output perf_conflicts[31:0], counting cycles with i_req=1 and d_req=1 both high. It saturates at 0xFFFFFFFF and resets to 0.
- Undefined: the port and the counter are absent.

Decomposition:
- Package mem_pkg holds:
  - Access encodings ACC_SB=3'b000, ACC_SH=3'b001, ACC_W=3'b010, ACC_UB=3'b100, ACC_UH=3'b101.
  - WORD_WIDTH.
  - The state enum {IDLE, RMW}.
- Sub-module mem_lane_align (combinational): load extract/extend and store merge, shared by the load and RMW paths.

Test Plan:
- i_req=1 alone, i_addr=0x8, RAM word[2]=0xDEADBEEF -> i_gnt in cycle 0; i_rvalid and i_rdata=0xDEADBEEF in cycle 1.
- d_req load, access=000, addr=0x7, word[1]=0x80112233 -> d_rdata=0xFFFFFF80; repeat with access=100 -> 0x00000080.
- Sub-word store: access=001, addr=0x6, wdata=0x0000ABCD, word[1]=0x11223344 -> read in cycle 0; write 0xABCD3344 with d_gnt in cycle 1; a subsequent word load returns 0xABCD3344.
- i_req and d_req loads held continuously, STARVE_LIMIT=4 -> after 4 data grants, fetch is granted once, then data resumes.
- Word store at addr=0x2 -> d_gnt=1 and d_err=1 in the same cycle; mem_en=0; RAM unchanged.
- rst_n pulsed low during the RMW cycle -> mem_we never asserted, outputs 0, RAM word unchanged.
